// File: rtl/conv_window_gen.sv
// Stride-2 4x4 window generator: 3 line buffers plus a 3-column shift register, and the live pixel forms the newest row/column.
// Window is registered 1 clock after the completing pixel is accepted; there is no backpressure, and idle cycles freeze all state.
module conv_window_gen #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [7:0]               in_pixel,
    output logic [127:0]             image_4x4,
    output logic                     image_valid,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic                     frame_done
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [RW-1:0] R_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] C_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] R_THREE = RW'(3);
    localparam logic [CW-1:0] C_THREE = CW'(3);

    logic [RW-1:0]  r_row;
    logic [CW-1:0]  r_col;
    logic [7:0]     r_lb0 [IMG_W];
    logic [7:0]     r_lb1 [IMG_W];
    logic [7:0]     r_lb2 [IMG_W];
    logic [7:0]     r_sh  [4][3];
    logic [127:0]   r_img;
    logic           r_img_vld;
    logic [RW-1:0]  r_win_row;
    logic [CW-1:0]  r_win_col;
    logic           r_frame_done;

    logic [RW-1:0]  w_r;
    logic [CW-1:0]  w_c;
    logic [RW-1:0]  w_r_off;
    logic [CW-1:0]  w_c_off;
    logic [7:0]     w_new [4];
    logic           w_emit;
    logic           w_last;
    logic [127:0]   w_win;

    // in_sof relocates the accepted pixel to (0,0); everything below uses the effective position.
    always_comb begin
        w_r      = in_sof ? '0 : r_row;
        w_c      = in_sof ? '0 : r_col;
        w_new[0] = r_lb0[w_c];
        w_new[1] = r_lb1[w_c];
        w_new[2] = r_lb2[w_c];
        w_new[3] = in_pixel;
        w_emit   = in_valid && (w_r >= R_THREE) && (w_c >= C_THREE) && w_r[0] && w_c[0];
        w_last   = in_valid && (w_r == R_LAST) && (w_c == C_LAST);
        w_r_off  = w_r - R_THREE;
        w_c_off  = w_c - C_THREE;
        w_win    = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_win[8*(4*i+j) +: 8] = r_sh[i][j];
            end
            w_win[8*(4*i+3) +: 8] = w_new[i];
        end
    end

    // Line buffers hold rows r-3..r-1; stale contents are masked by the row gate on emission.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_lb0[w_c] <= r_lb1[w_c];
            r_lb1[w_c] <= r_lb2[w_c];
            r_lb2[w_c] <= in_pixel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row        <= '0;
            r_col        <= '0;
            r_img        <= '0;
            r_img_vld    <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_sh[i][j] <= '0;
                end
            end
        end else begin
            r_img_vld    <= 1'b0;
            r_frame_done <= w_last;
            if (in_valid) begin
                if (w_c == C_LAST) begin
                    r_col <= '0;
                    r_row <= (w_r == R_LAST) ? '0 : w_r + RW'(1);
                end else begin
                    r_col <= w_c + CW'(1);
                    r_row <= w_r;
                end
                for (int i = 0; i < 4; i++) begin
                    r_sh[i][0] <= r_sh[i][1];
                    r_sh[i][1] <= r_sh[i][2];
                    r_sh[i][2] <= w_new[i];
                end
                if (w_emit) begin
                    r_img     <= w_win;
                    r_img_vld <= 1'b1;
                    r_win_row <= {1'b0, w_r_off[RW-1:1]};
                    r_win_col <= {1'b0, w_c_off[CW-1:1]};
                end
            end
        end
    end

    assign image_4x4   = r_img;
    assign image_valid = r_img_vld;
    assign win_row     = r_win_row;
    assign win_col     = r_win_col;
    assign frame_done  = r_frame_done;
endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: an image model pushes expected windows, and a negedge monitor pops and compares them.
module tb_conv_window_gen;
    localparam int W = 16;
    localparam int H = 16;
    localparam logic [127:0] WIN0   = 128'h33323130_23222120_13121110_03020100;
    localparam logic [127:0] WIN1   = 128'h35343332_25242322_15141312_05040302;
    localparam logic [127:0] WINL   = 128'hFFFEFDFC_EFEEEDEC_DFDEDDDC_CFCECDCC;
    localparam logic [127:0] WIN0_N = 128'hCCCDCECF_DCDDDEDF_ECEDEEEF_FCFDFEFF;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_sof = 1'b0;
    logic [7:0]   in_pixel = 8'h00;
    logic [127:0] image_4x4;
    logic         image_valid;
    logic [3:0]   win_row;
    logic [3:0]   win_col;
    logic         frame_done;

    typedef struct {
        logic [127:0] img;
        logic [3:0]   row;
        logic [3:0]   col;
        logic         fd;
    } exp_t;

    exp_t         q[$];
    logic [127:0] win_log[$];
    int           checks = 0;
    int           errors = 0;
    int           fd_cnt = 0;
    int           mdl[H][W];
    int           pr = 0;
    int           pc = 0;
    logic [127:0] last_img = '0;
    logic [3:0]   last_row = '0;
    logic [3:0]   last_col = '0;

    conv_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_pixel   (in_pixel),
        .image_4x4  (image_4x4),
        .image_valid(image_valid),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] logged(input int idx);
        return (idx < win_log.size()) ? win_log[idx] : 128'h0;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_img", image_4x4, 128'h0);
            chk("rst_ctl", 128'({image_valid, win_row, win_col, frame_done}), 128'h0);
            last_img = '0;
            last_row = '0;
            last_col = '0;
        end else if (image_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_window: got window %h, expected none", image_4x4);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("win_img", image_4x4, e.img);
                chk("win_row", 128'(win_row), 128'(e.row));
                chk("win_col", 128'(win_col), 128'(e.col));
                chk("win_fd", 128'(frame_done), 128'(e.fd));
                last_img = e.img;
                last_row = e.row;
                last_col = e.col;
            end
            win_log.push_back(image_4x4);
            if (frame_done) fd_cnt++;
        end else begin
            chk("hold_img", image_4x4, last_img);
            chk("hold_pos", 128'({win_row, win_col}), 128'({last_row, last_col}));
            chk("fd_alone", 128'(frame_done), 128'h0);
        end
    end

    task automatic send(input logic [7:0] pix, input logic sof);
        if (sof) begin
            pr = 0;
            pc = 0;
        end
        mdl[pr][pc] = int'(pix);
        if (pr >= 3 && pc >= 3 && (pr % 2) == 1 && (pc % 2) == 1) begin
            exp_t e;
            e.img = '0;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    e.img[8*(4*i+j) +: 8] = 8'(mdl[pr-3+i][pc-3+j]);
            e.row = 4'((pr - 3) / 2);
            e.col = 4'((pc - 3) / 2);
            e.fd  = (pr == H-1) && (pc == W-1);
            q.push_back(e);
        end
        in_valid = 1'b1;
        in_sof   = sof;
        in_pixel = pix;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (pc == W-1) begin
            pc = 0;
            pr = (pr == H-1) ? 0 : pr + 1;
        end else begin
            pc = pc + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // kind 0: 16r+c, kind 1: 0xFF-(16r+c); stops before pixel index stop_at when stop_at >= 0
    task automatic send_frame(input int kind, input logic with_sof, input int gap_pct, input int stop_at);
        for (int idx = 0; idx < W*H; idx++) begin
            logic [7:0] v;
            if (stop_at >= 0 && idx == stop_at) return;
            while ($urandom_range(0, 99) < gap_pct) idle(1);
            v = 8'(idx);
            if (kind == 1) v = 8'hFF - v;
            send(v, with_sof && idx == 0);
        end
    endtask

    task automatic phase_start();
        win_log.delete();
        fd_cnt = 0;
    endtask

    task automatic drain(input string name);
        idle(4);
        chk(name, 128'(q.size()), 128'h0);
    endtask

    initial begin
        idle(3);
        chk("reset_img", image_4x4, 128'h0);
        chk("reset_vld", 128'(image_valid), 128'h0);
        reset = 1'b0;
        idle(2);

        phase_start();
        send_frame(0, 1'b1, 0, -1);
        drain("p1_drain");
        chk("p1_count", 128'(win_log.size()), 128'd49);
        chk("p1_first", logged(0), WIN0);
        chk("p1_second", logged(1), WIN1);
        chk("p1_last", logged(48), WINL);
        chk("p1_fd", 128'(fd_cnt), 128'd1);

        phase_start();
        send_frame(0, 1'b1, 30, -1);
        drain("p2_drain");
        chk("p2_count", 128'(win_log.size()), 128'd49);
        chk("p2_first", logged(0), WIN0);
        chk("p2_last", logged(48), WINL);
        chk("p2_fd", 128'(fd_cnt), 128'd1);

        phase_start();
        send_frame(0, 1'b1, 0, -1);
        send_frame(1, 1'b0, 0, -1);
        drain("p3_drain");
        chk("p3_count", 128'(win_log.size()), 128'd98);
        chk("p3_f2_first", logged(49), WIN0_N);
        chk("p3_fd", 128'(fd_cnt), 128'd2);

        phase_start();
        send_frame(0, 1'b1, 0, 8*W + 5);
        send_frame(0, 1'b1, 0, -1);
        drain("p4_drain");
        chk("p4_count", 128'(win_log.size()), 128'd70);
        chk("p4_restart", logged(21), WIN0);
        chk("p4_fd", 128'(fd_cnt), 128'd1);

        phase_start();
        send_frame(0, 1'b1, 0, 5*W + 7);
        chk("p5_pre_count", 128'(win_log.size()), 128'd9);
        #1;
        reset = 1'b1;
        #1;
        chk("p5_async_img", image_4x4, 128'h0);
        chk("p5_async_ctl", 128'({image_valid, win_row, win_col, frame_done}), 128'h0);
        chk("p5_queue", 128'(q.size()), 128'h0);
        idle(2);
        reset = 1'b0;
        idle(1);
        phase_start();
        send_frame(0, 1'b1, 0, -1);
        drain("p5_drain");
        chk("p5_count", 128'(win_log.size()), 128'd49);
        chk("p5_first", logged(0), WIN0);
        chk("p5_fd", 128'(fd_cnt), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream feeder for the conv_pool stage.
- Accepts a raster-order 8-bit pixel stream and buffers three image lines plus the current line.
- Emits stride-2 4x4 pixel windows packed in the exact 128-bit image_4x4 format that conv_pool consumes.
- Each emitted window yields one pooled output downstream.

Parameters:
- IMG_W, 16, image width in pixels; must be even and >= 4.
- IMG_H, 16, image height in lines; must be even and >= 4.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_pixel is accepted this cycle when high; no backpressure.
- in_sof  input  1  start of frame; qualified by in_valid; marks the accepted pixel as (row 0, col 0).
- in_pixel  input  8  unsigned pixel.
- image_4x4  output  128  window; byte k = bits [8k+7:8k], k = 4*i + j holds pixel(r-3+i, c-3+j).
- image_valid  output  1  one-cycle pulse; image_4x4 is new this cycle.
- win_row  output  $clog2(IMG_H)  window row index = (r-3)/2.
- win_col  output  $clog2(IMG_W)  window column index = (c-3)/2.
- frame_done  output  1  one-cycle pulse, registered one cycle after the last pixel of a frame is accepted.

Behaviour:
- Reset (async, any time incl. mid-frame):
  - row/col counters = 0.
  - image_4x4 = 0, image_valid = 0, win_row = 0, win_col = 0, frame_done = 0.
  - Line-buffer contents need not be cleared; stale data is never emitted (see row/col gating).
- Pixel acceptance: only on cycles with in_valid = 1.
  - Idle cycles freeze counters, line buffers and window registers.
  - Outputs hold their last values; pulses drop to 0.
- Position tracking:
  - Accepted pixel is at (r, c).
  - After acceptance, c increments; at c = IMG_W-1 it wraps to 0 and r increments.
  - At (IMG_H-1, IMG_W-1) both wrap to 0, so back-to-back frames need no in_sof.
- in_sof:
  - in_valid & in_sof forces the accepted pixel to (0,0) regardless of current counters.
  - Counters then continue from (0,1).
  - No window is emitted until r >= 3 again.
- Storage: 3 line buffers of IMG_W x 8 bits plus a 4x4 byte window register.
  - Window column shift uses the 3 buffered pixels at column c plus in_pixel.
  - in_pixel forms row i = 3, the newest row.
- Emission: window completes when pixel (r, c) is accepted with r >= 3, c >= 3, r odd, c odd.
  - Next cycle: image_valid = 1, image_4x4 = window, win_row = (r-3)/2, win_col = (c-3)/2.
  - Latency: 1 clock from the accepting edge.
- Windows per frame: ((IMG_W-4)/2+1) * ((IMG_H-4)/2+1); 49 for the 16x16 default.
  - Window order: raster, win_col fastest.
- frame_done: asserted 1 cycle after pixel (IMG_H-1, IMG_W-1) is accepted.
  - For even IMG_W/IMG_H it coincides with the final image_valid pulse.
  - Not asserted when a frame is aborted by in_sof.
- Simultaneous events:
  - in_sof on a pixel that would otherwise complete a window: no window; that pixel is treated as (0,0).
  - reset has priority over everything.
- Pixel values are passed through unmodified; no arithmetic on data.

Test Plan:
- Single window at the frame origin (defaults):
  - Stimulus: reset 3 cycles, then stream pixel(r,c) = 16r+c continuously with in_sof on the first pixel.
  - First image_valid is 1 clock after pixel index 51 (r3,c3), with image_4x4 = 0x33323130_23222120_13121110_03020100, win_row = 0, win_col = 0.
- Second window and full-frame count (same stream as above):
  - Second window is 0x35343332_25242322_15141312_05040302 with win_col = 1.
  - Exactly 49 image_valid pulses per frame.
  - Last window byte15 = 0xFF, win_row = 6, win_col = 6, with frame_done high in the same cycle.
- Random in_valid gaps (30% idle) with the same frame:
  - Identical 49-window sequence as the continuous case.
  - Outputs hold during idle cycles; no extra or missing pulses.
- Back-to-back frames without in_sof, second frame pixels = 0xFF - (16r+c):
  - First window of frame 2 = byte-wise 0xFF complement of the frame-1 first window.
- Mid-frame in_sof at pixel (8,5):
  - No windows until 3 rows into the new frame.
  - Next window equals the frame-origin window with win_row = 0, win_col = 0.
  - No frame_done for the aborted frame.
- Reset asserted mid-frame at (5,7):
  - All outputs go to 0 immediately (asynchronously).
  - After release and a new frame with in_sof, the first window appears after (3,3) with correct data.
